// File: rtl/tdt_dmi_apb_rsp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdt_dmi_apb_rsp_if : APB3 signal bundle between DMI initiator/target  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface tdt_dmi_apb_rsp_if;
  logic        tdt_dmi_psel;
  logic        tdt_dmi_penable;
  logic        tdt_dmi_pwrite;
  logic [11:0] tdt_dmi_paddr;
  logic [31:0] tdt_dmi_pwdata;
  logic [31:0] tdt_dmi_prdata;
  logic        tdt_dmi_pready;
  logic        tdt_dmi_pslverr;

  modport master (
    output tdt_dmi_psel, tdt_dmi_penable, tdt_dmi_pwrite, tdt_dmi_paddr, tdt_dmi_pwdata,
    input  tdt_dmi_prdata, tdt_dmi_pready, tdt_dmi_pslverr
  );

  modport slave (
    input  tdt_dmi_psel, tdt_dmi_penable, tdt_dmi_pwrite, tdt_dmi_paddr, tdt_dmi_pwdata,
    output tdt_dmi_prdata, tdt_dmi_pready, tdt_dmi_pslverr
  );
endinterface
`default_nettype wire

// File: rtl/tdt_dmi_apb_rsp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdt_dmi_apb_rsp : APB3 DMI responder, data bank + WAIT_CFG/ID regs    |
// | Optional: TDT_DMI_APB_RSP_ERR_CNT_EN adds ERR_CNT at 0x3F4. Rev 1.0   |
// +----------------------------------------------------------------------+
module tdt_dmi_apb_rsp #(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VAL   = 32'h0C90_6001,
  parameter logic [3:0]  WAIT_RST = 4'd0
) (
  input  wire logic              sys_apb_clk,
  input  wire logic              sys_apb_rst,
  tdt_dmi_apb_rsp_if.slave       apb
);

  localparam logic [9:0] IDX_ERR_CNT = 10'd253;
  localparam logic [9:0] IDX_WAIT    = 10'd254;
  localparam logic [9:0] IDX_ID      = 10'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic [3:0]  wait_cfg_q, wait_cfg_d;
  logic [31:0] data_q [NUM_REGS];
  logic [31:0] data_d [NUM_REGS];
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
  logic [7:0]  err_cnt_q, err_cnt_d;
`endif

  logic [11:0] dec_addr;
  logic        dec_wr;
  logic [9:0]  dec_idx;
  logic        dec_err;
  logic [31:0] dec_rdata;
  logic        take_done;

  // With zero waits DONE is entered on the setup edge, so decode must see the live bus there.
  always_comb begin
    dec_addr  = (state_q == ST_IDLE) ? apb.tdt_dmi_paddr  : paddr_q;
    dec_wr    = (state_q == ST_IDLE) ? apb.tdt_dmi_pwrite : pwrite_q;
    dec_idx   = dec_addr[11:2];
    dec_err   = 1'b1;
    dec_rdata = '0;
    if (dec_addr[1:0] == 2'b00) begin
      if (dec_idx < 10'(NUM_REGS)) begin
        dec_err = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (dec_idx == 10'(k)) dec_rdata = data_q[k];
        end
      end else if (dec_idx == IDX_WAIT) begin
        dec_err   = 1'b0;
        dec_rdata = {28'd0, wait_cfg_q};
      end else if (dec_idx == IDX_ID) begin
        dec_err   = dec_wr;
        dec_rdata = ID_VAL;
      end
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
      else if (dec_idx == IDX_ERR_CNT) begin
        dec_err   = 1'b0;
        dec_rdata = {24'd0, err_cnt_q};
      end
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    wait_cfg_d = wait_cfg_q;
    data_d     = data_q;
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
    err_cnt_d  = err_cnt_q;
`endif
    take_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (apb.tdt_dmi_psel && !apb.tdt_dmi_penable) begin
          paddr_d  = apb.tdt_dmi_paddr;
          pwrite_d = apb.tdt_dmi_pwrite;
          pwdata_d = apb.tdt_dmi_pwdata;
          cnt_d    = wait_cfg_q;
          if (wait_cfg_q == 4'd0) begin
            state_d   = ST_DONE;
            take_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!apb.tdt_dmi_psel) begin
          state_d = ST_IDLE;
        end else if (apb.tdt_dmi_penable) begin
          if (cnt_q == 4'd1) begin
            state_d   = ST_DONE;
            take_done = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (pwrite_q && !pslverr_q) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (dec_idx == 10'(k)) data_d[k] = pwdata_q;
          end
          if (dec_idx == IDX_WAIT) wait_cfg_d = pwdata_q[3:0];
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
          if (dec_idx == IDX_ERR_CNT) err_cnt_d = 8'd0;
`endif
        end
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
        if (pslverr_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_done) begin
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      prdata_d  = (dec_err || dec_wr) ? 32'd0 : dec_rdata;
    end
  end

  always_ff @(posedge sys_apb_clk) begin
    if (sys_apb_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      wait_cfg_q <= WAIT_RST;
      for (int k = 0; k < NUM_REGS; k++) data_q[k] <= '0;
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      wait_cfg_q <= wait_cfg_d;
      data_q     <= data_d;
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign apb.tdt_dmi_prdata  = prdata_q;
  assign apb.tdt_dmi_pready  = pready_q;
  assign apb.tdt_dmi_pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_tdt_dmi_apb_rsp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tdt_dmi_apb_rsp : vector table, corner sequences, random vs model  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_tdt_dmi_apb_rsp;
  localparam int          NUM_REGS = 8;
  localparam logic [31:0] ID_VAL   = 32'h0C90_6001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdt_dmi_apb_rsp_if bus ();

  tdt_dmi_apb_rsp #(.NUM_REGS(NUM_REGS), .ID_VAL(ID_VAL), .WAIT_RST(4'd0)) dut (
    .sys_apb_clk (clk),
    .sys_apb_rst (rst),
    .apb         (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_data [NUM_REGS];
  int          m_wait;
  int          m_errcnt;

  function automatic vec_t mk(bit wr, logic [11:0] a, logic [31:0] wd, logic [31:0] rd, bit err, int cyc);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = err; v.exp_cyc = cyc;
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_data[k] = '0;
    m_wait   = 0;
    m_errcnt = 0;
  endfunction

  function automatic void model_access(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output bit err, output int cyc);
    int idx;
    idx = int'(a) / 4;
    cyc = m_wait + 1;
    err = 1'b1;
    rd  = '0;
    if (int'(a) % 4 == 0) begin
      if (idx < NUM_REGS) begin
        err = 1'b0;
        if (wr) m_data[idx] = wd; else rd = m_data[idx];
      end else if (a == 12'h3F8) begin
        err = 1'b0;
        if (wr) m_wait = int'(wd[3:0]); else rd = 32'(m_wait);
      end else if (a == 12'h3FC) begin
        err = wr;
        if (!wr) rd = ID_VAL;
      end
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
      else if (a == 12'h3F4) begin
        err = 1'b0;
        if (wr) m_errcnt = 0; else rd = 32'(m_errcnt);
      end
`endif
    end
    if (err && m_errcnt < 255) m_errcnt++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.tdt_dmi_psel    = 1'b0;
      bus.tdt_dmi_penable = 1'b0;
    end
  endtask

  // Leaves the bus in the DONE cycle so the next call can issue a back-to-back setup.
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int cyc);
    @(posedge clk); #1;
    bus.tdt_dmi_psel    = 1'b1;
    bus.tdt_dmi_penable = 1'b0;
    bus.tdt_dmi_pwrite  = wr;
    bus.tdt_dmi_paddr   = a;
    bus.tdt_dmi_pwdata  = wd;
    @(posedge clk); #1;
    bus.tdt_dmi_penable = 1'b1;
    cyc = 1;
    while (!bus.tdt_dmi_pready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd  = bus.tdt_dmi_prdata;
    err = bus.tdt_dmi_pslverr;
    if (!bus.tdt_dmi_pready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL xfer_timeout: addr %h got no pready expected pready within 40 cycles", a);
      cyc = -1;
    end
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.tdt_dmi_psel    = 1'b0;
    bus.tdt_dmi_penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd;
    logic        err;
    bit          exp_err;
    int          cyc, exp_cyc;
    logic [11:0] a;
    logic [31:0] wd;
    bit          wr;

    bus.tdt_dmi_psel    = 1'b0;
    bus.tdt_dmi_penable = 1'b0;
    bus.tdt_dmi_pwrite  = 1'b0;
    bus.tdt_dmi_paddr   = '0;
    bus.tdt_dmi_pwdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 32'(bus.tdt_dmi_pready), 32'd0);
    chk("rst_pslverr", 32'(bus.tdt_dmi_pslverr), 32'd0);
    chk("rst_prdata", bus.tdt_dmi_prdata, 32'd0);
    rst = 1'b0;

    // Directed vector table
    vecs.push_back(mk(0, 12'h3FC, 0,            ID_VAL,       0, 1));
    vecs.push_back(mk(1, 12'h008, 32'hDEADBEEF, 0,            0, 1));
    vecs.push_back(mk(0, 12'h008, 0,            32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(0, 12'h004, 0,            0,            0, 1));
    vecs.push_back(mk(0, 12'h00C, 0,            0,            0, 1));
    vecs.push_back(mk(1, 12'h3FC, 32'h1234,     0,            1, 1));
    vecs.push_back(mk(0, 12'h002, 0,            0,            1, 1));
    vecs.push_back(mk(0, 12'h200, 0,            0,            1, 1));
    vecs.push_back(mk(0, 12'h3FC, 0,            ID_VAL,       0, 1));
    vecs.push_back(mk(1, 12'h3F8, 32'h3,        0,            0, 1));
    vecs.push_back(mk(0, 12'h000, 0,            0,            0, 4));
    vecs.push_back(mk(0, 12'h3F8, 0,            32'h3,        0, 4));
    vecs.push_back(mk(1, 12'h3F8, 32'hFFFF_FFF0, 0,           0, 4));
    vecs.push_back(mk(0, 12'h3F8, 0,            32'h0,        0, 1));
`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
    vecs.push_back(mk(0, 12'h3F4, 0,            32'd3,        0, 1));
`else
    vecs.push_back(mk(0, 12'h3F4, 0,            0,            1, 1));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, cyc);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
    end

    // pready must be a single-cycle pulse with outputs cleared afterwards
    xfer(1, 12'h3F8, 32'd3, rd, err, cyc);
    xfer(0, 12'h008, 0, rd, err, cyc);
    chk("w3_rdata", rd, 32'hDEADBEEF);
    chk("w3_cycles", 32'(cyc), 32'd4);
    @(posedge clk); #1;
    chk("w3_pready_after", 32'(bus.tdt_dmi_pready), 32'd0);
    chk("w3_prdata_after", bus.tdt_dmi_prdata, 32'd0);
    xfer(1, 12'h3F8, 32'd5, rd, err, cyc);
    chk("w5_set_cycles", 32'(cyc), 32'd4);

    // Abort by dropping psel mid-WAIT: no write commits
    idle(1);
    @(posedge clk); #1;
    bus.tdt_dmi_psel = 1'b1; bus.tdt_dmi_penable = 1'b0;
    bus.tdt_dmi_pwrite = 1'b1; bus.tdt_dmi_paddr = 12'h000; bus.tdt_dmi_pwdata = 32'd1;
    @(posedge clk); #1;
    bus.tdt_dmi_penable = 1'b1;
    chk("abort_acc1_pready", 32'(bus.tdt_dmi_pready), 32'd0);
    @(posedge clk); #1;
    chk("abort_acc2_pready", 32'(bus.tdt_dmi_pready), 32'd0);
    @(posedge clk); #1;
    bus.tdt_dmi_psel = 1'b0; bus.tdt_dmi_penable = 1'b0;
    idle(6);
    chk("abort_idle_pready", 32'(bus.tdt_dmi_pready), 32'd0);
    xfer(0, 12'h000, 0, rd, err, cyc);
    chk("abort_data0", rd, 32'd0);
    chk("abort_read_cycles", 32'(cyc), 32'd6);

    // Reset in the middle of WAIT
    idle(1);
    @(posedge clk); #1;
    bus.tdt_dmi_psel = 1'b1; bus.tdt_dmi_penable = 1'b0;
    bus.tdt_dmi_pwrite = 1'b1; bus.tdt_dmi_paddr = 12'h000; bus.tdt_dmi_pwdata = 32'd1;
    @(posedge clk); #1;
    bus.tdt_dmi_penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pready", 32'(bus.tdt_dmi_pready), 32'd0);
    chk("midrst_pslverr", 32'(bus.tdt_dmi_pslverr), 32'd0);
    chk("midrst_prdata", bus.tdt_dmi_prdata, 32'd0);
    rst = 1'b0;
    bus.tdt_dmi_psel = 1'b0; bus.tdt_dmi_penable = 1'b0;
    model_reset();
    xfer(0, 12'h3F8, 0, rd, err, cyc);
    chk("midrst_wait_cfg", rd, 32'd0);
    chk("midrst_cycles", 32'(cyc), 32'd1);
    xfer(0, 12'h000, 0, rd, err, cyc);
    chk("midrst_data0", rd, 32'd0);
    xfer(0, 12'h008, 0, rd, err, cyc);
    chk("midrst_data2", rd, 32'd0);

`ifdef TDT_DMI_APB_RSP_ERR_CNT_EN
    for (int i = 0; i < 300; i++) xfer(0, 12'h002, 0, rd, err, cyc);
    xfer(0, 12'h3F4, 0, rd, err, cyc);
    chk("errcnt_sat", rd, 32'h0000_00FF);
    xfer(1, 12'h3F4, 32'h1234_5678, rd, err, cyc);
    chk("errcnt_clr_pslverr", 32'(err), 32'd0);
    xfer(0, 12'h3F4, 0, rd, err, cyc);
    chk("errcnt_after_clr", rd, 32'd0);
`endif

    // Randomised traffic against the reference model
    for (int i = 0; i < 250; i++) begin
      wr = bit'($urandom_range(0, 1));
      wd = $urandom();
      case ($urandom_range(0, 6))
        0, 1:    a = 12'($urandom_range(0, NUM_REGS - 1) * 4);
        2:       a = 12'h3F8;
        3:       a = 12'h3FC;
        4:       a = 12'h3F4;
        5:       a = {10'($urandom()), 2'($urandom_range(1, 3))};
        default: a = 12'($urandom());
      endcase
      model_access(wr, a, wd, exp_rd, exp_err, exp_cyc);
      xfer(wr, a, wd, rd, err, cyc);
      if (!wr) chk($sformatf("rnd%0d_rdata@%h", i, a), rd, exp_rd);
      chk($sformatf("rnd%0d_pslverr@%h", i, a), 32'(err), 32'(exp_err));
      chk($sformatf("rnd%0d_cycles@%h", i, a), 32'(cyc), 32'(exp_cyc));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
